// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode encoding shared by the ALU and its sequencer
package alu_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        ALU_ADD     = 3'd0,
        ALU_AND     = 3'd1,
        ALU_OR      = 3'd2,
        ALU_XOR     = 3'd3,
        ALU_NOT     = 3'd4,
        ALU_ROTR    = 3'd5,
        ALU_SHR     = 3'd6,
        ALU_ILLEGAL = 3'd7
    } alu_op_t;

    function automatic logic op_is_legal(input alu_op_t op);
        return op != ALU_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - requester, ALU and response signals of the shared ALU sequencer
interface alu_share_ctrl_if
    import alu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    alu_op_t [NREQ-1:0]          req_op;
    logic [NREQ-1:0][WIDTH-1:0]  req_a;
    logic [NREQ-1:0][WIDTH-1:0]  req_b;

    alu_op_t                     alu_op;
    logic [WIDTH-1:0]            alu_a;
    logic [WIDTH-1:0]            alu_b;
    logic [WIDTH-1:0]            alu_result;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [IDW-1:0]              resp_id;
    logic [WIDTH-1:0]            resp_data;
    logic                        resp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, resp_ready,
        output req_ready, alu_op, alu_a, alu_b, resp_valid, resp_id, resp_data, resp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, resp_ready,
        input  req_ready, alu_op, alu_a, alu_b, resp_valid, resp_id, resp_data, resp_err
    );

endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rtl/alu_share_ctrl_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_vld
);

    // Scan NREQ slots beginning one past the previous winner; last_grant itself is checked last.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!grant_vld && req[(int'(last_grant) + i) % NREQ]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'((int'(last_grant) + i) % NREQ);
            end
        end
    end

    assign grant = grant_vld ? (NREQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sequencer sharing one external ALU among NREQ requesters
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_share_ctrl_if.slave   bus
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNTW-1:0] CNT_INIT  = CNTW'(ALU_LAT - 1);
    localparam logic [IDW-1:0]  LAST_INIT = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t            state, state_n;
    logic [CNTW-1:0]   cnt;
    logic [IDW-1:0]    last_grant;
    logic [IDW-1:0]    resp_id_q;
    logic [WIDTH-1:0]  resp_data_q;
    logic              resp_err_q;
    alu_op_t           alu_op_q;
    logic [WIDTH-1:0]  alu_a_q;
    logic [WIDTH-1:0]  alu_b_q;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              grant_vld;
    logic              accept;
    alu_op_t           sel_op;
    logic              sel_legal;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    // Grant is only offered while idle, so a response handshake and a new grant never overlap.
    always_comb begin
        state_n       = state;
        accept        = 1'b0;
        bus.req_ready = '0;
        sel_op        = bus.req_op[grant_idx];
        sel_legal     = op_is_legal(sel_op);
        unique case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    accept        = 1'b1;
                    bus.req_ready = grant;
                    state_n       = sel_legal ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                if (cnt == '0) state_n = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // ALU operand registers load only for legal ops, so an illegal request leaves the ALU inputs quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            last_grant  <= LAST_INIT;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            alu_op_q    <= ALU_ADD;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        last_grant <= grant_idx;
                        resp_id_q  <= grant_idx;
                        if (sel_legal) begin
                            alu_op_q <= sel_op;
                            alu_a_q  <= bus.req_a[grant_idx];
                            alu_b_q  <= bus.req_b[grant_idx];
                            cnt      <= CNT_INIT;
                        end else begin
                            resp_err_q  <= 1'b1;
                            resp_data_q <= '0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        resp_data_q <= bus.alu_result;
                        resp_err_q  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl at ALU_LAT 1 and 3
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus0 ();
    alu_share_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus1 ();

    alu_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .ALU_LAT(LAT0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    alu_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .ALU_LAT(LAT1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~a;
            3'd5:    return (a >> b[4:0]) | (a << (32 - int'(b[4:0])));
            3'd6:    return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    logic [NREQ-1:0]             rv  [2];
    alu_op_t [NREQ-1:0]          rop [2];
    logic [NREQ-1:0][WIDTH-1:0]  ra  [2];
    logic [NREQ-1:0][WIDTH-1:0]  rb  [2];
    logic                        rr  [2];

    wire [NREQ-1:0]  rdy   [2];
    wire             rvld  [2];
    wire [1:0]       rid   [2];
    wire [31:0]      rdata [2];
    wire             rerr  [2];
    wire [2:0]       aop   [2];
    wire [31:0]      aa    [2];
    wire [31:0]      ab    [2];

    assign bus0.req_valid  = rv[0];
    assign bus0.req_op     = rop[0];
    assign bus0.req_a      = ra[0];
    assign bus0.req_b      = rb[0];
    assign bus0.resp_ready = rr[0];
    assign bus0.alu_result = alu_ref(bus0.alu_op, bus0.alu_a, bus0.alu_b);
    assign bus1.req_valid  = rv[1];
    assign bus1.req_op     = rop[1];
    assign bus1.req_a      = ra[1];
    assign bus1.req_b      = rb[1];
    assign bus1.resp_ready = rr[1];
    assign bus1.alu_result = alu_ref(bus1.alu_op, bus1.alu_a, bus1.alu_b);

    assign rdy[0]   = bus0.req_ready;   assign rdy[1]   = bus1.req_ready;
    assign rvld[0]  = bus0.resp_valid;  assign rvld[1]  = bus1.resp_valid;
    assign rid[0]   = bus0.resp_id;     assign rid[1]   = bus1.resp_id;
    assign rdata[0] = bus0.resp_data;   assign rdata[1] = bus1.resp_data;
    assign rerr[0]  = bus0.resp_err;    assign rerr[1]  = bus1.resp_err;
    assign aop[0]   = bus0.alu_op;      assign aop[1]   = bus1.alu_op;
    assign aa[0]    = bus0.alu_a;       assign aa[1]    = bus1.alu_a;
    assign ab[0]    = bus0.alu_b;       assign ab[1]    = bus1.alu_b;

    // Reference state: who was served last, and what the ALU was last asked to do.
    int          last_g  [2];
    logic [2:0]  prev_op [2];
    logic [31:0] prev_a  [2];
    logic [31:0] prev_b  [2];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_g[k]  = NREQ - 1;
            prev_op[k] = 3'd0;
            prev_a[k]  = 32'h0;
            prev_b[k]  = 32'h0;
        end
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_req_ready", rdy[k], 0);
        chk("rst_resp_valid", rvld[k], 0);
        chk("rst_resp_id", rid[k], 0);
        chk("rst_resp_data", rdata[k], 0);
        chk("rst_resp_err", rerr[k], 0);
        chk("rst_alu_op", aop[k], 0);
        chk("rst_alu_a", aa[k], 0);
        chk("rst_alu_b", ab[k], 0);
    endtask

    task automatic set_req(input int k, input int i, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        rv[k][i]  = 1'b1;
        rop[k][i] = op;
        ra[k][i]  = a;
        rb[k][i]  = b;
    endtask

    // Entered and left at a falling edge; drives one request through grant, ALU, and response.
    task automatic txn(input int k, input int hold, output int gid, output int wt,
                       output logic [31:0] data, output logic err);
        int          exp_g;
        int          g;
        int          lat;
        logic [2:0]  op;
        logic [31:0] a, b, exp_d;
        logic        exp_e;
        gid   = -1;
        wt    = 0;
        data  = '0;
        err   = 1'b0;
        exp_g = -1;
        for (int i = 1; i <= NREQ; i++)
            if (exp_g < 0 && rv[k][(last_g[k] + i) % NREQ]) exp_g = (last_g[k] + i) % NREQ;
        rr[k] = (hold == 0);
        #1;
        chk("idle_resp_valid", rvld[k], 0);
        while (rdy[k] == '0 && wt < 20) begin
            @(negedge clk); #1;
            wt++;
        end
        if (rdy[k] == '0) begin
            chk("grant_timeout", wt, 0);
            return;
        end
        chk("grant_onehot", rdy[k], (exp_g < 0) ? 64'h0 : (64'h1 << exp_g));
        g = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (rdy[k][i]) g = i;
        gid = g;
        op  = rop[k][g];
        a   = ra[k][g];
        b   = rb[k][g];
        last_g[k] = g;
        if (op != 3'd7) begin
            exp_d = alu_ref(op, a, b);
            exp_e = 1'b0;
            prev_op[k] = op;
            prev_a[k]  = a;
            prev_b[k]  = b;
        end else begin
            exp_d = 32'h0;
            exp_e = 1'b1;
        end
        @(negedge clk);
        rv[k][g] = 1'b0;
        #1;
        lat = 1;
        while (!rvld[k] && lat < 20) begin
            chk("exec_req_ready", rdy[k], 0);
            chk("exec_alu_op", aop[k], prev_op[k]);
            chk("exec_alu_a", aa[k], prev_a[k]);
            chk("exec_alu_b", ab[k], prev_b[k]);
            @(negedge clk); #1;
            lat++;
        end
        chk("resp_latency", lat, (op != 3'd7) ? lat_of(k) + 1 : 1);
        if (!rvld[k]) return;
        for (int h = 0; h < hold; h++) begin
            chk("bp_resp_valid", rvld[k], 1);
            chk("bp_req_ready", rdy[k], 0);
            chk("bp_resp_data", rdata[k], exp_d);
            @(negedge clk);
            if (h == hold - 1) rr[k] = 1'b1;
            #1;
        end
        chk("resp_valid", rvld[k], 1);
        chk("resp_id", rid[k], g);
        chk("resp_data", rdata[k], exp_d);
        chk("resp_err", rerr[k], exp_e);
        chk("resp_alu_op", aop[k], prev_op[k]);
        chk("resp_alu_a", aa[k], prev_a[k]);
        chk("resp_alu_b", ab[k], prev_b[k]);
        data = rdata[k];
        err  = rerr[k];
        @(negedge clk);
    endtask

    task automatic rand_phase(input int k, input int n);
        int          gid, wt, j;
        logic [31:0] d;
        logic        e;
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rv[k][i] && $urandom_range(7) == 0)
                    rv[k][i] = 1'b0;
                else if (!rv[k][i] && $urandom_range(1) == 1)
                    set_req(k, i, alu_op_t'($urandom_range(7)), $urandom,
                            ($urandom_range(3) == 0) ? 32'($urandom_range(31)) : $urandom);
            end
            if (rv[k] == '0) begin
                j = $urandom_range(NREQ - 1);
                set_req(k, j, alu_op_t'($urandom_range(7)), $urandom, $urandom);
            end
            txn(k, $urandom_range(3), gid, wt, d, e);
        end
        rv[k] = '0;
    endtask

    initial begin
        int          gid, wt, quiet;
        logic [31:0] d;
        logic        e;
        for (int k = 0; k < 2; k++) begin
            rv[k] = '0;  rop[k] = '0;  ra[k] = '0;  rb[k] = '0;  rr[k] = 1'b1;
        end
        model_reset();
        rst = 1'b1;
        #12;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NREQ; i++) set_req(0, i, ALU_ADD, 32'(i), 32'd1);
        for (int j = 0; j < NREQ; j++) begin
            txn(0, 0, gid, wt, d, e);
            chk("rr_order", gid, j);
            chk("rr_data", d, j + 1);
            chk("rr_grant_wait", wt, 0);
        end
        set_req(0, 0, ALU_ADD, 32'd7, 32'd8);
        set_req(0, 2, ALU_ADD, 32'd9, 32'd9);
        txn(0, 0, gid, wt, d, e);
        chk("wrap_id", gid, 0);
        chk("wrap_data", d, 15);
        txn(0, 0, gid, wt, d, e);
        chk("wrap_next_id", gid, 2);
        chk("wrap_next_data", d, 18);

        set_req(0, 0, ALU_XOR, 32'h5, 32'h4);
        txn(0, 0, gid, wt, d, e);
        chk("xor_id", gid, 0);
        chk("xor_data", d, 32'h1);
        chk("xor_err", e, 0);

        set_req(0, 2, ALU_ILLEGAL, $urandom, $urandom);
        txn(0, 0, gid, wt, d, e);
        chk("ill_id", gid, 2);
        chk("ill_data", d, 0);
        chk("ill_err", e, 1);

        set_req(0, 1, ALU_ROTR, 32'h0000_0001, 32'd1);
        txn(0, 0, gid, wt, d, e);
        chk("rotr_id", gid, 1);
        chk("rotr_data", d, 32'h8000_0000);

        set_req(1, 3, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        txn(1, 5, gid, wt, d, e);
        chk("bp_id", gid, 3);
        chk("bp_data_final", d, 32'h00F0_1234);

        rand_phase(0, 40);
        rand_phase(1, 40);

        set_req(1, 0, ALU_ADD, 32'd3, 32'd4);
        #1;
        chk("mid_exec_grant", rdy[1], 1);
        @(negedge clk);
        rv[1] = '0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (rvld[0] || rvld[1]) quiet++;
        end
        chk("no_resp_after_reset", quiet, 0);
        @(negedge clk);
        set_req(1, 0, ALU_OR, 32'h00FF_0000, 32'h0000_00FF);
        set_req(1, 1, ALU_SHR, 32'h8000_0000, 32'd4);
        txn(1, 0, gid, wt, d, e);
        chk("post_rst_first_id", gid, 0);
        chk("post_rst_first_data", d, 32'h00FF_00FF);
        txn(1, 1, gid, wt, d, e);
        chk("post_rst_second_id", gid, 1);
        chk("post_rst_second_data", d, 32'h0800_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
